spdif_src_arbiter: RTL and testbench
====================================

Name: spdif_src_arbiter

Overview:
- Shares the S/PDIF transmitter between two 32-bit sample sources (for example I2S capture and a test-tone generator).
- Presents one word per transmitter sample request.
- Switches between sources only on S/PDIF block boundaries (BLOCK_LEN frames), so channel-status blocks are never split between sources.
- Inserts mute words on underrun and counts underruns. Sits between the sources and the transmitter's sample_i / sample_req_o pair.

Parameters:
- DATA_W, 32, width of sample words.
- BLOCK_LEN, 192, frames per S/PDIF block; grant changes only at block wrap.
- IDX_W, 8, width of the frame index; must satisfy 2^IDX_W >= BLOCK_LEN.
- UCNT_W, 16, width of the underrun counter.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- s0_tdata_i  in  DATA_W  source 0 sample word
- s0_tvalid_i  in  1  source 0 word valid
- s0_tready_o  out  1  source 0 word consumed this cycle
- s0_en_i  in  1  source 0 requests the transmitter
- s1_tdata_i  in  DATA_W  source 1 sample word
- s1_tvalid_i  in  1  source 1 word valid
- s1_tready_o  out  1  source 1 word consumed this cycle
- s1_en_i  in  1  source 1 requests the transmitter
- prio_i  in  1  preferred source when both are enabled (0 = s0, 1 = s1)
- sample_req_i  in  1  one-cycle pulse from the transmitter; it captures sample_o in this cycle
- sample_o  out  DATA_W  registered word offered to the transmitter
- grant_o  out  2  one-hot current owner; 00 = none
- frame_idx_o  out  IDX_W  block index of the word currently in sample_o
- block_start_o  out  1  one-cycle pulse when a word with index 0 is loaded
- underrun_o  out  1  one-cycle pulse on underrun
- underrun_cnt_o  out  UCNT_W  saturating underrun count

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE, sample_o = 0, frame_idx_o = 0, grant_o = 00.
  - block_start_o = 0, underrun_o = 0, underrun_cnt_o = 0.
  - Reset wins over a simultaneous sample_req_i. Reset mid-block abandons the block and drops the grant immediately.
- States:
  - IDLE: no owner, mute.
  - RUN0: s0 owns the transmitter.
  - RUN1: s1 owns the transmitter.
  - DRAIN: the owner deasserted its enable mid-block; mute until the boundary.
- grant_o encoding: RUN0 = 01, RUN1 = 10. IDLE and DRAIN = 00.
- Events occur only in cycles where sample_req_i = 1. No change otherwise.
- Each sample_req_i cycle counts as a consumption, including back-to-back cycles.
- Next index: nidx = (frame_idx_o == BLOCK_LEN-1) ? 0 : frame_idx_o + 1. frame_idx_o <= nidx at the same edge.
- Boundary decision (nidx == 0):
  - Candidates are the enabled sources.
  - Both enabled: owner = prio_i. One enabled: owner = that source. None enabled: IDLE.
  - prio_i and the enable inputs are sampled only here.
  - The new owner supplies the index-0 word at this same edge.
  - block_start_o = 1 the following cycle.
- Mid-block, owner enable low: RUN0/RUN1 -> DRAIN at this request. The source is not read and a 0 word is loaded.
- Mid-block, the non-owner's enable has no effect until the boundary.
- Word load while owning (RUN0/RUN1, owner enabled):
  - tvalid = 1: sample_o <= owner tdata, and owner tready_o = 1 combinationally in this same cycle (tready = sample_req_i & owner & state & tvalid).
  - tvalid = 0: sample_o <= 0, underrun_o pulses next cycle, underrun_cnt_o increments and saturates at all-ones.
- In IDLE and DRAIN: sample_o <= 0, no tready, no underrun.
- Non-owner tready_o is always 0. No word is ever duplicated or dropped from the owner's stream.
- First block after reset is silent. The transmitter takes reset word index 0, and the first grant decision is made at the first wrap.
- Latency: a word accepted at request N is transmitted at request N+1.

Test Plan:
- Reset, then s0_en = 1 with s0 always valid (tdata = 0x00A5_0000 + k), BLOCK_LEN = 4:
  - Requests 1-3 load 0 with grant 00.
  - Request 4 loads 0x00A50000 with grant 01 and block_start_o pulses.
  - Request 5 captures 0x00A50000.
- Both enabled, prio_i = 1 at a wrap -> grant 10. s0_tready_o stays 0 for the whole block. Flip prio_i mid-block -> no change until the next wrap.
- Owner s0 drops s0_en at frame 2 of 4:
  - Frames 2-3 load 0 and state is DRAIN.
  - At the wrap, s1 is granted if enabled, else grant 00.
- Owner valid low for 3 requests -> three 0 words and three underrun_o pulses, underrun_cnt_o = 3. With UCNT_W = 2, 5 underruns -> count stays 3.
- sample_req_i high for 2 consecutive cycles -> two sequential source words consumed in order with two tready pulses.
- rst_i together with sample_req_i mid-block -> all outputs at reset values and no tready asserted in that cycle.

Source files
------------

// File: rtl/spdif_src_arbiter.sv
// spdif_src_arbiter
//   Shares one S/PDIF transmitter between two sample sources. One word is
//   presented per transmitter sample request. Ownership only changes when
//   the frame index wraps, so a channel-status block never mixes sources.
//   Underruns are replaced by mute words and counted.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   s0_*/s1_*               source streams: tdata/tvalid in, tready out,
//                           en_i requests ownership at the next block wrap
//   prio_i                  preferred source when both are enabled (0=s0)
//   sample_req_i            transmitter request; it captures sample_o now
//   sample_o                registered word offered to the transmitter
//   grant_o                 one-hot current owner, 00 = none
//   frame_idx_o             block index of the word in sample_o
//   block_start_o           pulse after an index-0 word was loaded
//   underrun_o              pulse after a mute word replaced a missing one
//   underrun_cnt_o          saturating underrun count
module spdif_src_arbiter #(
    parameter int DATA_W    = 32,
    parameter int BLOCK_LEN = 192,
    parameter int IDX_W     = 8,
    parameter int UCNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] s0_tdata_i,
    input  logic              s0_tvalid_i,
    output logic              s0_tready_o,
    input  logic              s0_en_i,
    input  logic [DATA_W-1:0] s1_tdata_i,
    input  logic              s1_tvalid_i,
    output logic              s1_tready_o,
    input  logic              s1_en_i,
    input  logic              prio_i,
    input  logic              sample_req_i,
    output logic [DATA_W-1:0] sample_o,
    output logic [1:0]        grant_o,
    output logic [IDX_W-1:0]  frame_idx_o,
    output logic              block_start_o,
    output logic              underrun_o,
    output logic [UCNT_W-1:0] underrun_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN0  = 2'd1,
        RUN1  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [IDX_W-1:0]    nidx;
    logic                wrap;
    logic [DATA_W-1:0]   word_d;
    logic                take0;
    logic                take1;
    logic                underrun_d;

    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (&v) ? v : v + UCNT_W'(1);
    endfunction

    // Index of the word about to be loaded; the wrap is where ownership
    // is decided.
    assign nidx = (frame_idx_o == IDX_W'(BLOCK_LEN - 1)) ? '0 : frame_idx_o + IDX_W'(1);
    assign wrap = (nidx == '0);

    always_comb begin
        state_d    = state_q;
        word_d     = '0;
        take0      = 1'b0;
        take1      = 1'b0;
        underrun_d = 1'b0;
        if (sample_req_i) begin
            if (wrap) begin
                if (s0_en_i && s1_en_i) begin
                    state_d = prio_i ? RUN1 : RUN0;
                end else if (s0_en_i) begin
                    state_d = RUN0;
                end else if (s1_en_i) begin
                    state_d = RUN1;
                end else begin
                    state_d = IDLE;
                end
            end else if ((state_q == RUN0 && !s0_en_i) || (state_q == RUN1 && !s1_en_i)) begin
                // Owner withdrew mid-block: stay silent until the wrap
                // rather than handing over a partial block.
                state_d = DRAIN;
            end

            // The (possibly new) owner supplies the word loaded at this edge.
            case (state_d)
                RUN0: begin
                    if (s0_tvalid_i) begin
                        word_d = s0_tdata_i;
                        take0  = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                RUN1: begin
                    if (s1_tvalid_i) begin
                        word_d = s1_tdata_i;
                        take1  = 1'b1;
                    end else begin
                        underrun_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset discards the request, so nothing may be consumed in that cycle.
    assign s0_tready_o = take0 & ~rst_i;
    assign s1_tready_o = take1 & ~rst_i;

    always_comb begin
        case (state_q)
            RUN0:    grant_o = 2'b01;
            RUN1:    grant_o = 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            sample_o       <= '0;
            frame_idx_o    <= '0;
            block_start_o  <= 1'b0;
            underrun_o     <= 1'b0;
            underrun_cnt_o <= '0;
        end else begin
            block_start_o <= 1'b0;
            underrun_o    <= 1'b0;
            if (sample_req_i) begin
                state_q       <= state_d;
                sample_o      <= word_d;
                frame_idx_o   <= nidx;
                block_start_o <= wrap;
                underrun_o    <= underrun_d;
                if (underrun_d) begin
                    underrun_cnt_o <= sat_inc(underrun_cnt_o);
                end
            end
        end
    end

endmodule

// File: tb/tb_spdif_src_arbiter.sv
// Bench for spdif_src_arbiter: a table of directed vectors, a few
// hand-written multi-cycle sequences and a randomized phase, all compared
// against a behavioural model of ownership per block.
module tb_spdif_src_arbiter;

    localparam int DATA_W    = 32;
    localparam int BLOCK_LEN = 4;
    localparam int IDX_W     = 3;
    localparam int UCNT_W    = 2;
    localparam int UCNT_MAX  = (1 << UCNT_W) - 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [DATA_W-1:0] s0_tdata_i = '0;
    logic              s0_tvalid_i = 1'b0;
    logic              s0_tready_o;
    logic              s0_en_i = 1'b0;
    logic [DATA_W-1:0] s1_tdata_i = '0;
    logic              s1_tvalid_i = 1'b0;
    logic              s1_tready_o;
    logic              s1_en_i = 1'b0;
    logic              prio_i = 1'b0;
    logic              sample_req_i = 1'b0;
    logic [DATA_W-1:0] sample_o;
    logic [1:0]        grant_o;
    logic [IDX_W-1:0]  frame_idx_o;
    logic              block_start_o;
    logic              underrun_o;
    logic [UCNT_W-1:0] underrun_cnt_o;

    spdif_src_arbiter #(
        .DATA_W(DATA_W), .BLOCK_LEN(BLOCK_LEN), .IDX_W(IDX_W), .UCNT_W(UCNT_W)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .s0_tdata_i(s0_tdata_i), .s0_tvalid_i(s0_tvalid_i), .s0_tready_o(s0_tready_o), .s0_en_i(s0_en_i),
        .s1_tdata_i(s1_tdata_i), .s1_tvalid_i(s1_tvalid_i), .s1_tready_o(s1_tready_o), .s1_en_i(s1_en_i),
        .prio_i(prio_i), .sample_req_i(sample_req_i),
        .sample_o(sample_o), .grant_o(grant_o), .frame_idx_o(frame_idx_o),
        .block_start_o(block_start_o), .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: owner is 0, 1 or -1 (nobody: idle or draining, both mute).
    int          m_owner = -1;
    int          m_idx   = 0;
    logic [31:0] m_sample = '0;
    bit          m_bs = 1'b0;
    bit          m_ur = 1'b0;
    int          m_cnt = 0;
    logic [31:0] k0 = '0;
    logic [31:0] k1 = '0;
    logic        obs_t0;
    logic        obs_t1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] grant_of(input int owner);
        return (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
    endfunction

    // One clock: apply inputs, predict, check tready before the edge and
    // registered outputs just after it.
    task automatic do_cycle(input bit r, input bit e0, input bit v0, input bit e1,
                            input bit v1, input bit pr, input bit rq);
        int          nown;
        int          nidx;
        logic [31:0] nsample;
        bit          nbs;
        bit          nur;
        int          ncnt;
        bit          t0;
        bit          t1;
        rst_i = r; s0_en_i = e0; s0_tvalid_i = v0; s1_en_i = e1; s1_tvalid_i = v1;
        prio_i = pr; sample_req_i = rq;
        s0_tdata_i = 32'h00A5_0000 + k0;
        s1_tdata_i = 32'h00B1_0000 + k1;
        nown = m_owner; nidx = m_idx; nsample = m_sample; nbs = 0; nur = 0; ncnt = m_cnt;
        t0 = 0; t1 = 0;
        if (r) begin
            nown = -1; nidx = 0; nsample = '0; ncnt = 0;
        end else if (rq) begin
            nidx = (m_idx + 1) % BLOCK_LEN;
            if (nidx == 0) begin
                if (e0 && e1) nown = pr ? 1 : 0;
                else if (e0)  nown = 0;
                else if (e1)  nown = 1;
                else          nown = -1;
            end else if ((m_owner == 0 && !e0) || (m_owner == 1 && !e1)) begin
                nown = -1;
            end
            nsample = '0;
            if (nown == 0) begin
                if (v0) begin nsample = s0_tdata_i; t0 = 1; end else nur = 1;
            end else if (nown == 1) begin
                if (v1) begin nsample = s1_tdata_i; t1 = 1; end else nur = 1;
            end
            if (nur && ncnt < UCNT_MAX) ncnt++;
            nbs = (nidx == 0);
        end
        @(negedge clk_i);
        obs_t0 = s0_tready_o;
        obs_t1 = s1_tready_o;
        check("s0_tready", 32'(s0_tready_o), 32'(t0));
        check("s1_tready", 32'(s1_tready_o), 32'(t1));
        @(posedge clk_i);
        m_owner = nown; m_idx = nidx; m_sample = nsample; m_bs = nbs; m_ur = nur; m_cnt = ncnt;
        if (t0) k0++;
        if (t1) k1++;
        #1;
        check("sample_o", sample_o, m_sample);
        check("grant_o", 32'(grant_o), 32'(grant_of(m_owner)));
        check("frame_idx_o", 32'(frame_idx_o), 32'(m_idx));
        check("block_start_o", 32'(block_start_o), 32'(m_bs));
        check("underrun_o", 32'(underrun_o), 32'(m_ur));
        check("underrun_cnt_o", 32'(underrun_cnt_o), 32'(m_cnt));
    endtask

    typedef struct {
        bit          r, e0, v0, e1, v1, pr, rq;
        logic [31:0] sample;
        logic [1:0]  grant;
        bit          bs;
        bit          t0;
    } vec_t;

    vec_t vecs[9];

    initial begin
        // Reset, s0 enabled and always valid: silent first block, then s0.
        vecs[0] = '{1,0,0,0,0,0,0, 32'h0,          2'b00, 0, 0};
        vecs[1] = '{0,1,1,0,0,0,1, 32'h0,          2'b00, 0, 0};
        vecs[2] = '{0,1,1,0,0,0,1, 32'h0,          2'b00, 0, 0};
        vecs[3] = '{0,1,1,0,0,0,1, 32'h0,          2'b00, 0, 0};
        vecs[4] = '{0,1,1,0,0,0,1, 32'h00A5_0000,  2'b01, 1, 1};
        vecs[5] = '{0,1,1,0,0,0,0, 32'h00A5_0000,  2'b01, 0, 0};
        vecs[6] = '{0,1,1,0,0,0,1, 32'h00A5_0001,  2'b01, 0, 1};
        vecs[7] = '{0,1,1,0,0,0,1, 32'h00A5_0002,  2'b01, 0, 1};
        // Reset together with a mid-block request.
        vecs[8] = '{1,1,1,0,0,0,1, 32'h0,          2'b00, 0, 0};

        @(posedge clk_i);
        #1;
        foreach (vecs[i]) begin
            do_cycle(vecs[i].r, vecs[i].e0, vecs[i].v0, vecs[i].e1, vecs[i].v1, vecs[i].pr, vecs[i].rq);
            check($sformatf("vec%0d_sample", i), sample_o, vecs[i].sample);
            check($sformatf("vec%0d_grant", i), 32'(grant_o), 32'(vecs[i].grant));
            check($sformatf("vec%0d_bs", i), 32'(block_start_o), 32'(vecs[i].bs));
            check($sformatf("vec%0d_t0", i), 32'(obs_t0), 32'(vecs[i].t0));
        end

        // Both enabled, prio = 1 at the wrap: s1 wins; flipping prio
        // mid-block changes nothing until the next wrap.
        for (int i = 0; i < 4; i++) do_cycle(0, 1,1, 1,1, 1, 1);
        check("prio_grant", 32'(grant_o), 32'(2'b10));
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 1,1, 1,1, 0, 1);
            check("prio_hold", 32'(grant_o), 32'(2'b10));
            check("prio_s0_idle", 32'(obs_t0), 32'(0));
        end
        do_cycle(0, 1,1, 1,1, 0, 1);
        check("prio_next_wrap", 32'(grant_o), 32'(2'b01));

        // Owner s0 drops its enable at frame 2: mute until the wrap, then s1.
        do_cycle(0, 1,1, 0,1, 0, 1);
        do_cycle(0, 0,1, 0,1, 0, 1);
        check("drain_grant", 32'(grant_o), 32'(2'b00));
        check("drain_word", sample_o, 32'h0);
        do_cycle(0, 0,1, 1,1, 0, 1);
        check("drain_word3", sample_o, 32'h0);
        do_cycle(0, 0,1, 1,1, 0, 1);
        check("drain_handover", 32'(grant_o), 32'(2'b10));

        // s1 underruns: three, then two more against a 2-bit counter.
        for (int i = 0; i < 3; i++) begin
            do_cycle(0, 0,0, 1,0, 0, 1);
            check("underrun_pulse", 32'(underrun_o), 32'(1));
        end
        check("underrun_cnt3", 32'(underrun_cnt_o), 32'd3);
        do_cycle(0, 0,0, 1,0, 0, 0);
        check("underrun_quiet", 32'(underrun_o), 32'(0));
        for (int i = 0; i < 2; i++) do_cycle(0, 0,0, 1,0, 0, 1);
        check("underrun_sat", 32'(underrun_cnt_o), 32'd3);

        // Randomized phase.
        begin
            bit re0 = 1, re1 = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 9) == 0) re0 = ~re0;
                if ($urandom_range(0, 9) == 0) re1 = ~re1;
                do_cycle($urandom_range(0, 199) == 0, re0, $urandom_range(0, 3) != 0,
                         re1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                         $urandom_range(0, 1) == 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
